serial_tx_sched: RTL and testbench

//  Schedules the single serial transmitter (datatosent/transenable/charsent) between two byte sources:
//  CPU writes and echo of received chars. Each source has a small FIFO; a round-robin arbiter picks
//  the next byte, holds tx_enable until the transmitter reports the char sent, and enforces an

---
 rtl/serial_tx_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_tx_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler that feeds one serial transmitter from a CPU FIFO and an echo FIFO.
// It holds each char until the transmitter reports it sent, then enforces an inter-char gap and a stall timeout.

module serial_tx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] head_c,
  output logic              full_o,
  output logic              empty_o,
  output logic              empty_nxt_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              wr_ok, rd_ok;

  // A write is judged against the registered full flag, so a pop in the same cycle never makes room.
  assign wr_ok       = wr_i & ~full_q;
  assign rd_ok       = rd_i & ~empty_q;
  assign head_c      = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign empty_nxt_c = (cnt_d == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_ok && !rd_ok) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_ok && rd_ok) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module serial_tx_sched #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wr,
  output logic              cpu_full,
  input  logic [DATA_W-1:0] echo_data,
  input  logic              echo_wr,
  input  logic              echo_en,
  output logic [7:0]        echo_drop_cnt,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_enable,
  input  logic              tx_char_sent,
  input  logic              clr_err,
  output logic              timeout_err,
  output logic              src_last,
  output logic              busy
);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_enable_q, tx_enable_d;
  logic              src_last_q, src_last_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
  logic [7:0]        drop_q, drop_d;
  logic              sent_q;

  logic [DATA_W-1:0] cpu_head, echo_head;
  logic              cpu_full_w, cpu_empty, cpu_empty_nxt, cpu_pop;
  logic              echo_full, echo_empty, echo_empty_nxt, echo_pop;
  logic              cpu_elig, echo_elig, grant, grant_echo;
  logic              sent_edge, tmr_done, gap_done;

  serial_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_cpu_fifo (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .wr_i        (cpu_wr),
    .wdata_i     (cpu_data),
    .rd_i        (cpu_pop),
    .head_c      (cpu_head),
    .full_o      (cpu_full_w),
    .empty_o     (cpu_empty),
    .empty_nxt_c (cpu_empty_nxt)
  );

  serial_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_echo_fifo (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .wr_i        (echo_wr & echo_en),
    .wdata_i     (echo_data),
    .rd_i        (echo_pop),
    .head_c      (echo_head),
    .full_o      (echo_full),
    .empty_o     (echo_empty),
    .empty_nxt_c (echo_empty_nxt)
  );

  // Round-robin: when both sources are eligible, the one not served last wins.
  assign cpu_elig   = ~cpu_empty;
  assign echo_elig  = ~echo_empty & echo_en;
  assign grant      = (state_q == ST_IDLE) & (cpu_elig | echo_elig);
  assign grant_echo = (cpu_elig & echo_elig) ? ~src_last_q : echo_elig;
  assign sent_edge  = tx_char_sent & ~sent_q;
  assign tmr_done   = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign gap_done   = (gap_q == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_SEND;
      ST_SEND: if (sent_edge || tmr_done) state_d = ST_GAP;
      ST_GAP:  if (gap_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_d         = tmr_q;
    gap_d         = gap_q;
    tx_data_d     = tx_data_q;
    src_last_d    = src_last_q;
    cpu_pop       = 1'b0;
    echo_pop      = 1'b0;
    timeout_err_d = timeout_err_q;
    if (clr_err) timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          tmr_d      = '0;
          src_last_d = grant_echo;
          tx_data_d  = grant_echo ? echo_head : cpu_head;
          cpu_pop    = ~grant_echo;
          echo_pop   = grant_echo;
        end
      end
      ST_SEND: begin
        tmr_d = tmr_q + TMR_W'(1);
        gap_d = '0;
        // An edge arriving on the last allowed cycle still counts as a clean send.
        if (!sent_edge && tmr_done) timeout_err_d = 1'b1;
      end
      ST_GAP:  gap_d = gap_q + GAP_W'(1);
      default: ;
    endcase
    tx_enable_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE) | ~cpu_empty_nxt | ~echo_empty_nxt;
    drop_d      = drop_q;
    if (echo_wr && echo_en && echo_full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // sent_q resets high so a transmitter stuck at done never looks like a fresh edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tmr_q         <= '0;
      gap_q         <= '0;
      tx_data_q     <= '0;
      tx_enable_q   <= 1'b0;
      src_last_q    <= 1'b1;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      drop_q        <= '0;
      sent_q        <= 1'b1;
    end else begin
      tmr_q         <= tmr_d;
      gap_q         <= gap_d;
      tx_data_q     <= tx_data_d;
      tx_enable_q   <= tx_enable_d;
      src_last_q    <= src_last_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      drop_q        <= drop_d;
      sent_q        <= tx_char_sent;
    end
  end

  assign cpu_full      = cpu_full_w;
  assign echo_drop_cnt = drop_q;
  assign tx_data       = tx_data_q;
  assign tx_enable     = tx_enable_q;
  assign timeout_err   = timeout_err_q;
  assign src_last      = src_last_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_serial_tx_sched.sv
// Directed bench for serial_tx_sched: a scoreboard of expected tx bytes plus cycle-exact flag checks.
module tb_serial_tx_sched;
  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic [7:0] cpu_data = '0;
  logic       cpu_wr = 1'b0;
  logic       cpu_full;
  logic [7:0] echo_data = '0;
  logic       echo_wr = 1'b0;
  logic       echo_en = 1'b0;
  logic [7:0] echo_drop_cnt;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_char_sent = 1'b0;
  logic       clr_err = 1'b0;
  logic       timeout_err;
  logic       src_last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic prev_en = 1'b0;

  serial_tx_sched #(.DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(16), .GAP_CYC(2)) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .cpu_data      (cpu_data),
    .cpu_wr        (cpu_wr),
    .cpu_full      (cpu_full),
    .echo_data     (echo_data),
    .echo_wr       (echo_wr),
    .echo_en       (echo_en),
    .echo_drop_cnt (echo_drop_cnt),
    .tx_data       (tx_data),
    .tx_enable     (tx_enable),
    .tx_char_sent  (tx_char_sent),
    .clr_err       (clr_err),
    .timeout_err   (timeout_err),
    .src_last      (src_last),
    .busy          (busy)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  // Each new char (tx_enable rising) must carry the next scoreboard byte.
  always @(negedge clk_clk) begin
    if (reset_reset) begin
      prev_en <= 1'b0;
    end else begin
      if (tx_enable && !prev_en) begin
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_en <= tx_enable;
    end
  end

  task automatic finish_char();
    int w;
    w = 0;
    while (tx_enable !== 1'b1 && w < 60) begin
      tick(1);
      w++;
    end
    chk("wait_tx_enable", 32'(tx_enable), 32'd1);
    tx_char_sent = 1'b1;
    tick(1);
    chk("tx_enable_fall", 32'(tx_enable), 32'd0);
    tx_char_sent = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 60) begin
      tick(1);
      w++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    tick(3);
    reset_reset = 1'b0;

    // 1: reset state and single CPU byte latency
    chk("rst_tx_enable", 32'(tx_enable), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_cpu_full", 32'(cpu_full), 32'd0);
    chk("rst_drop", 32'(echo_drop_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_src_last", 32'(src_last), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    cpu_data = 8'h41; cpu_wr = 1'b1; exp_q.push_back(8'h41);
    tick(1);
    cpu_wr = 1'b0;
    chk("t1_en_c1", 32'(tx_enable), 32'd0);
    tick(1);
    chk("t1_en_c2", 32'(tx_enable), 32'd1);
    chk("t1_data_c2", 32'(tx_data), 32'h41);
    tick(8);
    tx_char_sent = 1'b1;
    tick(1);
    chk("t1_en_c11", 32'(tx_enable), 32'd0);
    chk("t1_busy_c11", 32'(busy), 32'd1);
    tx_char_sent = 1'b0;
    tick(2);
    chk("t1_busy_c13", 32'(busy), 32'd0);
    chk("t1_src_last", 32'(src_last), 32'd0);

    // 2: round-robin order 01, A1, 02, A2 (01 goes alone, then CPU was last served)
    echo_en = 1'b1;
    cpu_data = 8'h01; cpu_wr = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'hA1); exp_q.push_back(8'h02); exp_q.push_back(8'hA2);
    tick(1);
    cpu_data = 8'h02; echo_data = 8'hA1; echo_wr = 1'b1;
    tick(1);
    cpu_wr = 1'b0; echo_data = 8'hA2;
    tick(1);
    echo_wr = 1'b0;
    repeat (4) finish_char();
    chk("t2_src_last", 32'(src_last), 32'd1);
    wait_idle();

    // 3: echo overflow and CPU full while the first echo byte is stalled
    exp_q.push_back(8'hE0);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'hC0 + 8'(k));
      exp_q.push_back(8'hE1 + 8'(k));
    end
    for (int i = 0; i < 6; i++) begin
      echo_data = 8'hE0 + 8'(i); echo_wr = 1'b1;
      tick(1);
    end
    echo_wr = 1'b0;
    chk("t3_drop", 32'(echo_drop_cnt), 32'd1);
    chk("t3_en_stall", 32'(tx_enable), 32'd1);
    for (int j = 0; j < 5; j++) begin
      chk("t3_cpu_full", 32'(cpu_full), (j == 4) ? 32'd1 : 32'd0);
      cpu_data = 8'hC0 + 8'(j); cpu_wr = 1'b1;
      tick(1);
    end
    cpu_wr = 1'b0;
    chk("t3_cpu_full_hold", 32'(cpu_full), 32'd1);
    chk("t3_drop_hold", 32'(echo_drop_cnt), 32'd1);
    repeat (9) finish_char();
    chk("t3_cpu_full_end", 32'(cpu_full), 32'd0);
    wait_idle();
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: timeout after 16 SEND cycles, sticky until cleared
    cpu_data = 8'h55; cpu_wr = 1'b1; exp_q.push_back(8'h55);
    tick(1);
    cpu_wr = 1'b0;
    tick(16);
    chk("t4_en_c17", 32'(tx_enable), 32'd1);
    chk("t4_err_c17", 32'(timeout_err), 32'd0);
    tick(1);
    chk("t4_en_c18", 32'(tx_enable), 32'd0);
    chk("t4_err_c18", 32'(timeout_err), 32'd1);
    tick(5);
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t4_err_clr", 32'(timeout_err), 32'd0);
    wait_idle();

    // 5: reset mid-SEND with tx_char_sent stuck high; queued 0x22 is discarded
    cpu_data = 8'h11; cpu_wr = 1'b1; exp_q.push_back(8'h11);
    tick(1);
    cpu_data = 8'h22;
    tick(1);
    cpu_wr = 1'b0;
    chk("t5_en_c2", 32'(tx_enable), 32'd1);
    tick(1);
    reset_reset = 1'b1; tx_char_sent = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    chk("t5_en_rst", 32'(tx_enable), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_data_rst", 32'(tx_data), 32'd0);
    chk("t5_src_rst", 32'(src_last), 32'd1);
    cpu_data = 8'h33; cpu_wr = 1'b1; exp_q.push_back(8'h33);
    tick(1);
    cpu_wr = 1'b0;
    tick(1);
    chk("t5_en_new", 32'(tx_enable), 32'd1);
    tick(2);
    chk("t5_stuck_no_edge", 32'(tx_enable), 32'd1);
    tx_char_sent = 1'b0;
    tick(1);
    tx_char_sent = 1'b1;
    tick(1);
    chk("t5_real_edge", 32'(tx_enable), 32'd0);
    tx_char_sent = 1'b0;
    wait_idle();

    // 6: echo disabled writes vanish; edge coinciding with timeout is not an error
    echo_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      echo_data = 8'hB0 + 8'(i); echo_wr = 1'b1;
      tick(1);
    end
    echo_wr = 1'b0;
    tick(4);
    chk("t6_en_off", 32'(tx_enable), 32'd0);
    chk("t6_busy_off", 32'(busy), 32'd0);
    chk("t6_drop_off", 32'(echo_drop_cnt), 32'd0);
    echo_en = 1'b1;
    tick(3);
    chk("t6_nothing_queued", 32'(tx_enable), 32'd0);
    cpu_data = 8'h77; cpu_wr = 1'b1; exp_q.push_back(8'h77);
    tick(1);
    cpu_wr = 1'b0;
    tick(16);
    chk("t6_en_c17", 32'(tx_enable), 32'd1);
    tx_char_sent = 1'b1;
    tick(1);
    chk("t6_en_c18", 32'(tx_enable), 32'd0);
    chk("t6_err_c18", 32'(timeout_err), 32'd0);
    tx_char_sent = 1'b0;
    wait_idle();
    chk("t6_err_end", 32'(timeout_err), 32'd0);
    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
